// File: rtl/mux4_x1_pkg.sv
// mux4_x1_pkg
//   Shared constants for the 4:1 selector slice: the default data width
//   and the four select encodings used by both the selector and the bench.
package mux4_x1_pkg;

  localparam int MUX_WIDTH_DEF = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN0 = 2'b00;
  localparam sel_t SEL_IN1 = 2'b01;
  localparam sel_t SEL_IN2 = 2'b10;
  localparam sel_t SEL_IN3 = 2'b11;

endpackage : mux4_x1_pkg

// File: rtl/mux4_x1_if.sv
// mux4_x1_if
//   Bundles the data sources, select, capture enable and all results of
//   mux4_x1.
//   master : drives in0..in3, sel, en; observes out, out_q, out_valid, sel_q
//   slave  : the selector itself (mirror image of master)
interface mux4_x1_if #(
  parameter int WIDTH = mux4_x1_pkg::MUX_WIDTH_DEF
);

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  logic [1:0]       sel_q;

  modport master (
    output in0, in1, in2, in3, sel, en,
    input  out, out_q, out_valid, sel_q
  );

  modport slave (
    input  in0, in1, in2, in3, sel, en,
    output out, out_q, out_valid, sel_q
  );

endinterface : mux4_x1_if

// File: rtl/mux4_x1_outreg.sv
// mux4_x1_outreg
//   En-gated capture register for the selected data and its select code.
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  asynchronous active-low reset, clears everything at once
//     i_en     capture enable
//     i_data   selected data to capture
//     i_sel    select code to capture alongside the data
//     o_data   captured data
//     o_sel    captured select code
//     o_vld    set by the first capture after reset, held until reset
module mux4_x1_outreg #(
  parameter int DATA_W = mux4_x1_pkg::MUX_WIDTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_sel,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_sel,
  output logic              o_vld
);

  logic [DATA_W-1:0] r_data_p1;
  logic [1:0]        r_sel_p1;
  logic              r_vld_p1;

  // Stage p0 -> p1: capture on en, hold otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_p1 <= '0;
      r_sel_p1  <= 2'b00;
      r_vld_p1  <= 1'b0;
    end else if (i_en) begin
      r_data_p1 <= i_data;
      r_sel_p1  <= i_sel;
      r_vld_p1  <= 1'b1;
    end
  end

  assign o_data = r_data_p1;
  assign o_sel  = r_sel_p1;
  assign o_vld  = r_vld_p1;

endmodule : mux4_x1_outreg

// File: rtl/mux4_x1.sv
// mux4_x1
//   4:1 selector with a combinational result and an en-gated registered copy.
//   Ports:
//     clk   rising-edge clock for the registered path
//     rst   asynchronous active-low reset of the registered path only
//     bus   mux4_x1_if slave: in0..in3, sel, en in; out (combinational),
//           out_q / sel_q (registered), out_valid out
module mux4_x1 #(
  parameter int WIDTH = mux4_x1_pkg::MUX_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mux4_x1_if.slave    bus
);

  import mux4_x1_pkg::*;

  logic [WIDTH-1:0] w_mux_p0;

  // Stage p0: purely combinational select, independent of clk/rst/en
  always_comb begin
    w_mux_p0 = '0;
    case (bus.sel)
      SEL_IN0: w_mux_p0 = bus.in0;
      SEL_IN1: w_mux_p0 = bus.in1;
      SEL_IN2: w_mux_p0 = bus.in2;
      SEL_IN3: w_mux_p0 = bus.in3;
      default: w_mux_p0 = '0;
    endcase
  end

  assign bus.out = w_mux_p0;

  mux4_x1_outreg #(
    .DATA_W (WIDTH)
  ) u_outreg (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (bus.en),
    .i_data  (w_mux_p0),
    .i_sel   (bus.sel),
    .o_data  (bus.out_q),
    .o_sel   (bus.sel_q),
    .o_vld   (bus.out_valid)
  );

endmodule : mux4_x1

// File: tb/tb_mux4_x1.sv
module tb_mux4_x1;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  mux4_x1_if #(.WIDTH(W)) bus ();

  mux4_x1 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state of the registered path
  logic [W-1:0] m_q;
  logic [1:0]   m_sel;
  logic         m_vld;

  function automatic logic [W-1:0] ref_out();
    logic [W-1:0] v [4];
    v[0] = bus.in0;
    v[1] = bus.in1;
    v[2] = bus.in2;
    v[3] = bus.in3;
    return v[bus.sel];
  endfunction

  // One rising edge; model captures the values present before the edge.
  task automatic tick();
    logic         cap;
    logic [W-1:0] nq;
    logic [1:0]   ns;
    cap = bus.en && rst;
    nq  = ref_out();
    ns  = bus.sel;
    @(posedge clk);
    if (cap && rst) begin
      m_q   = nq;
      m_sel = ns;
      m_vld = 1'b1;
    end
    #1;
  endtask

  task automatic randomize_inputs();
    bus.in0 = W'($urandom);
    bus.in1 = W'($urandom);
    bus.in2 = W'($urandom);
    bus.in3 = W'($urandom);
    bus.sel = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.sel = 2'b00; bus.en = 1'b0;
    #2;
    rst = 1'b0;
    m_q = '0; m_sel = 2'b00; m_vld = 1'b0;
    #1;
    checks++;
    if (bus.out_q !== '0) begin
      failures++; $display("FAIL reset_out_q actual=%h required=%h", bus.out_q, 16'h0);
    end
    checks++;
    if (bus.sel_q !== 2'b00) begin
      failures++; $display("FAIL reset_sel_q actual=%b required=00", bus.sel_q);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid);
    end
  endtask

  task automatic test_comb_tables();
    logic [W-1:0] exp_a [4];
    logic [W-1:0] exp_b [4];
    exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    exp_b = '{16'h000F, 16'h000E, 16'h000D, 16'h000C};
    bus.in0 = 16'h0000; bus.in1 = 16'h0001; bus.in2 = 16'h0002; bus.in3 = 16'h0003;
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #5;
      checks++;
      if (bus.out !== exp_a[s]) begin
        failures++; $display("FAIL comb_a sel=%0d actual=%h required=%h", s, bus.out, exp_a[s]);
      end
    end
    bus.in0 = 16'h000F; bus.in1 = 16'h000E; bus.in2 = 16'h000D; bus.in3 = 16'h000C;
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #5;
      checks++;
      if (bus.out !== exp_b[s]) begin
        failures++; $display("FAIL comb_b sel=%0d actual=%h required=%h", s, bus.out, exp_b[s]);
      end
    end
  endtask

  task automatic test_unselected();
    logic [W-1:0] keep;
    bus.sel = 2'b10;
    bus.in2 = 16'h5A3C;
    keep    = bus.in2;
    for (int i = 0; i < 6; i++) begin
      bus.in0 = W'($urandom);
      bus.in1 = W'($urandom);
      bus.in3 = W'($urandom);
      #1;
      checks++;
      if (bus.out !== keep) begin
        failures++; $display("FAIL unselected_toggle i=%0d actual=%h required=%h", i, bus.out, keep);
      end
    end
    bus.in2 = 16'hA5A5;
    #0;
    #0;
    checks++;
    if (bus.out !== 16'hA5A5) begin
      failures++; $display("FAIL selected_change actual=%h required=%h", bus.out, 16'hA5A5);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst = 1'b1;
    randomize_inputs();
    bus.sel = 2'b11;
    bus.in3 = 16'h1234;
    bus.en  = 1'b1;
    tick();
    checks++;
    if (bus.out_q !== 16'h1234) begin
      failures++; $display("FAIL capture_out_q actual=%h required=%h", bus.out_q, 16'h1234);
    end
    checks++;
    if (bus.sel_q !== 2'b11) begin
      failures++; $display("FAIL capture_sel_q actual=%b required=11", bus.sel_q);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL capture_out_valid actual=%b required=1", bus.out_valid);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] q0;
    logic [1:0]   s0;
    logic         v0;
    q0 = m_q; s0 = m_sel; v0 = m_vld;
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      #1;
      checks++;
      if (bus.out !== ref_out()) begin
        failures++; $display("FAIL hold_out i=%0d actual=%h required=%h", i, bus.out, ref_out());
      end
      tick();
      checks++;
      if (bus.out_q !== q0 || bus.sel_q !== s0 || bus.out_valid !== v0) begin
        failures++;
        $display("FAIL hold_regs i=%0d actual=%h/%b/%b required=%h/%b/%b",
                 i, bus.out_q, bus.sel_q, bus.out_valid, q0, s0, v0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      bus.en = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (bus.out !== ref_out()) begin
        failures++; $display("FAIL rand_out i=%0d actual=%h required=%h", i, bus.out, ref_out());
      end
      tick();
      // Disturb inputs right after the edge; the capture must already be settled
      randomize_inputs();
      #1;
      checks++;
      if (bus.out_q !== m_q || bus.sel_q !== m_sel || bus.out_valid !== m_vld) begin
        failures++;
        $display("FAIL rand_regs i=%0d actual=%h/%b/%b required=%h/%b/%b",
                 i, bus.out_q, bus.sel_q, bus.out_valid, m_q, m_sel, m_vld);
      end
    end
  endtask

  task automatic test_async_reset();
    randomize_inputs();
    bus.en = 1'b1;
    tick();
    #3;
    rst = 1'b0;
    bus.en = 1'b1;
    m_q = '0; m_sel = 2'b00; m_vld = 1'b0;
    #1;
    checks++;
    if (bus.out_q !== '0 || bus.sel_q !== 2'b00 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_clear actual=%h/%b/%b required=0000/00/0",
               bus.out_q, bus.sel_q, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      #1;
      checks++;
      if (bus.out !== ref_out()) begin
        failures++; $display("FAIL rst_out_follow i=%0d actual=%h required=%h", i, bus.out, ref_out());
      end
      tick();
      checks++;
      if (bus.out_q !== '0 || bus.sel_q !== 2'b00 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_overrides_en i=%0d actual=%h/%b/%b required=0000/00/0",
                 i, bus.out_q, bus.sel_q, bus.out_valid);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0;
    randomize_inputs();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL post_rst_no_en actual=%b required=0", bus.out_valid);
    end
    randomize_inputs();
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.out_q !== m_q || bus.sel_q !== m_sel || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_first_capture actual=%h/%b/%b required=%h/%b/1",
               bus.out_q, bus.sel_q, bus.out_valid, m_q, m_sel);
    end
  endtask

  initial begin
    test_reset();
    test_comb_tables();
    test_unselected();
    test_capture();
    test_hold();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux4_x1

// File: doc/mux4_x1.md
MUX4_X1 -- requirements
Module: mux4_x1

Interface
REQ-001 Parameter WIDTH, default 16, data width of every data input and output.
REQ-002 clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in0  input  WIDTH  data source 0.
REQ-005 in1  input  WIDTH  data source 1.
REQ-006 in2  input  WIDTH  data source 2.
REQ-007 in3  input  WIDTH  data source 3.
REQ-008 sel  input  2  source select: 00=in0, 01=in1, 10=in2, 11=in3.
REQ-009 en  input  1  capture enable for the registered path.
REQ-010 out  output  WIDTH  combinational selected data.
REQ-011 out_q  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_q holds data captured since reset.
REQ-013 sel_q  output  2  select value captured together with out_q.

Function
REQ-014 out SHALL equal the source named by sel, purely combinational, zero clock latency, with no dependency on clk, rst or en.
REQ-015 out SHALL update in the same delta as any change on sel or on the currently selected input; changes on unselected inputs SHALL have no effect on out.
REQ-016 out SHALL be a full-width, bit-exact copy; no truncation, sign-extension or inversion.
REQ-017 Narrower values driven onto the inputs are zero-extended by the driver; out SHALL carry them unchanged.
REQ-018 If sel contains X or Z, out is don't-care; no error output is required.
REQ-019 On a rising clk edge with en=1: out_q <= current out, sel_q <= sel, out_valid <= 1.
REQ-020 On a rising clk edge with en=0: out_q, sel_q and out_valid SHALL hold their values.
REQ-021 The registered path latency is exactly one cycle from the en=1 edge.
REQ-022 out_valid SHALL stay 1 until the next reset; there is no deassertion other than reset.
REQ-023 If sel and an input change in the same cycle as an en=1 edge, the values present before the edge SHALL be captured.

Reset
REQ-024 While rst=0: out_q=0, sel_q=2'b00, out_valid=0, applied immediately without waiting for clk.
REQ-025 If rst is asserted mid-operation, it SHALL override en and clear the registered state at once; out SHALL continue to follow sel combinationally.
REQ-026 After rst deasserts, the first capture SHALL occur on the first rising edge with en=1.

Structure
REQ-027 A shared package SHALL hold the WIDTH default (16) and the four select encodings as named constants (SEL_IN0..SEL_IN3).
REQ-028 The combinational selector SHALL be a case on sel covering all four encodings, with a default of all-zero for synthesis completeness.
REQ-029 One sub-module, mux4_x1_outreg, SHALL hold the en-gated output and select register with asynchronous active-low reset; the top instantiates it once.

Verification
REQ-030 in0..in3=0x0000,0x0001,0x0002,0x0003; sel=00,01,10,11 in 5-unit steps -> out=0x0000,0x0001,0x0002,0x0003 in the same step, with no clock.
REQ-031 in0..in3=0x000F,0x000E,0x000D,0x000C; sel=00,01,10,11 -> out=0x000F,0x000E,0x000D,0x000C.
REQ-032 sel=10 held; toggle in0, in1 and in3 -> out stays equal to in2; change in2 to 0xA5A5 -> out=0xA5A5 immediately.
REQ-033 rst=0 -> out_q=0, sel_q=00, out_valid=0 without a clock edge; release rst, sel=11, in3=0x1234, en=1, one edge -> out_q=0x1234, sel_q=11, out_valid=1.
REQ-034 en=0 across 3 edges while in0..in3 and sel change -> out_q, sel_q and out_valid unchanged while out tracks sel.
REQ-035 Assert rst between edges while out_valid=1 -> registered outputs clear immediately, and en=1 has no effect while rst=0.
